// File: rtl/grant_owner_ctrl.sv
// rtl/grant_owner_ctrl.sv - requester-side owner control for an 8-way one-hot arbiter
// Optional grant sanity checking is enabled with `define GRANT_CHECK_EN.
module grant_owner_ctrl #(
  parameter int BURST = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       req_pulse,
  input  logic [7:0]       grant,
  input  logic             hold,
  output logic [7:0]       pend,
  output logic             owner_valid,
  output logic [7:0]       owner_onehot,
  output logic [2:0]       owner_idx,
  output logic [7:0]       done,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    RETIRE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BURST - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [7:0]       onehot_next;
  logic [2:0]       idx_next;
  logic [7:0]       pend_next;
  logic [7:0]       clr;
  logic [7:0]       grant_low;
  logic [2:0]       grant_enc;

  // Isolate the lowest set grant bit so a malformed grant still yields one owner.
  assign grant_low = grant & (~grant + 8'd1);

  always_comb begin
    grant_enc = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (grant_low[i]) begin
        grant_enc = 3'(i);
      end
    end
  end

  assign owner_valid = (state == OWN);
  assign busy        = (state != IDLE);
  assign done        = (state == RETIRE) ? owner_onehot : 8'h00;
  assign clr         = done;

  // Set wins over clear, so a strobe in the retire cycle re-queues the client.
  assign pend_next = (pend & ~clr) | req_pulse;

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    onehot_next = owner_onehot;
    idx_next    = owner_idx;
    case (state)
      IDLE: begin
        if ((pend != 8'h00) && (grant != 8'h00)) begin
          onehot_next = grant_low;
          idx_next    = grant_enc;
          cnt_next    = CNT_LOAD;
          state_next  = OWN;
        end
      end
      OWN: begin
        if (!hold) begin
          if (cnt != '0) begin
            cnt_next = cnt - CNT_W'(1);
          end else begin
            state_next = RETIRE;
          end
        end
      end
      RETIRE: begin
        onehot_next = 8'h00;
        idx_next    = 3'd0;
        state_next  = IDLE;
      end
      default: begin
        onehot_next = 8'h00;
        idx_next    = 3'd0;
        cnt_next    = '0;
        state_next  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      owner_onehot <= 8'h00;
      owner_idx    <= 3'd0;
      pend         <= 8'h00;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      owner_onehot <= onehot_next;
      owner_idx    <= idx_next;
      pend         <= pend_next;
    end
  end

`ifdef GRANT_CHECK_EN
  logic bad_grant;

  // Not one-hot (zero or several bits) or granting a client that is not pending.
  assign bad_grant = (state == IDLE) && (pend != 8'h00) &&
                     ((grant == 8'h00) || (grant_low != grant) || ((grant & ~pend) != 8'h00));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (bad_grant) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule
